// File: rtl/uart_fifo_loopback.sv
// UART receiver and transmitter joined by a byte FIFO. Received frames are queued and
// drained by TX either automatically (echo) or one frame per uart_tx_start rising edge.
module uart_fifo_loopback #(
  parameter int unsigned CLOCK_FREQ = 10000000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx_d_in,
  input  logic                          uart_tx_start,
  input  logic                          auto_echo,
  input  logic [1:0]                    freq_control,
  input  logic                          clear_err,
  output logic                          uart_tx_d_out,
  output logic                          uart_rx_valid,
  output logic                          uart_tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned Div0 = (CLOCK_FREQ + 4800) / 9600;
  localparam int unsigned Div1 = (CLOCK_FREQ + 9600) / 19200;
  localparam int unsigned Div2 = (CLOCK_FREQ + 28800) / 57600;
  localparam int unsigned Div3 = (CLOCK_FREQ + 57600) / 115200;
  localparam int unsigned CntW = $clog2(Div0 + 1);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] Div0W = CntW'(Div0);
  localparam logic [CntW-1:0] Div1W = CntW'(Div1);
  localparam logic [CntW-1:0] Div2W = CntW'(Div2);
  localparam logic [CntW-1:0] Div3W = CntW'(Div3);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
  localparam logic [CW-1:0]   FullCnt = CW'(FIFO_DEPTH);

  function automatic logic [CntW-1:0] div_sel(input logic [1:0] code);
    logic [CntW-1:0] d;
    unique case (code)
      2'b00:   d = Div0W;
      2'b01:   d = Div1W;
      2'b10:   d = Div2W;
      default: d = Div3W;
    endcase
    return d;
  endfunction

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  rx_state_e              rx_state_q;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0]        rx_cnt_q, rx_div_q;
  logic [BitW-1:0]        rx_bits_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic                   rx_par_q;

  tx_state_e              tx_state_q;
  logic [CntW-1:0]        tx_cnt_q, tx_div_q;
  logic [BitW-1:0]        tx_bits_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic                   tx_par_q;
  logic                   tx_start_q;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_d;

  logic rx_tick, rx_done, par_bad, rx_good;
  logic tx_tick, start_rise, fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FullCnt);

  assign rx_tick = (rx_cnt_q == rx_div_q - 1'b1);
  assign rx_done = (rx_state_q == RxStop) && rx_tick;
  assign par_bad = PARITY_EN && (rx_par_q != ((^rx_shift_q) ^ PARITY_ODD));
  assign rx_good = rx_done && rx_sync_q && !par_bad;

  assign tx_tick    = (tx_cnt_q == tx_div_q - 1'b1);
  assign start_rise = uart_tx_start && !tx_start_q;
  // In echo mode the next frame is launched straight out of the stop bit, leaving no gap.
  assign pop  = !fifo_empty &&
                (((tx_state_q == TxIdle) && (auto_echo || start_rise)) ||
                 ((tx_state_q == TxStop) && tx_tick && auto_echo));
  assign push = rx_good && (!fifo_full || pop);

  // ---------------- RX ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q    <= RxIdle;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_cnt_q      <= '0;
      rx_div_q      <= '0;
      rx_bits_q     <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_data       <= '0;
      uart_rx_valid <= 1'b0;
    end else begin
      rx_meta_q     <= uart_rx_d_in;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      uart_rx_valid <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_sel(freq_control);
          end
        end
        RxStart: begin
          if (rx_cnt_q == (rx_div_q >> 1) - 1'b1) begin
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bits_q  <= rx_bits_q + 1'b1;
            if (rx_bits_q == LastBit) begin
              if (PARITY_EN) rx_state_q <= RxParity;
              else           rx_state_q <= RxStop;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxParity: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            if (rx_good) begin
              rx_data       <= rx_shift_q;
              uart_rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // A new error in the clearing cycle wins over clear_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun    <= (overrun & ~clear_err) | (rx_good & fifo_full & ~pop);
      frame_err  <= (frame_err & ~clear_err) | (rx_done & ~rx_sync_q);
      parity_err <= (parity_err & ~clear_err) | (rx_done & par_bad);
    end
  end

  // ---------------- FIFO ----------------
  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + 1'b1;
    else if (!push && pop) count_d = fifo_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_count <= count_d;
    end
  end

  // ---------------- TX ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q    <= TxIdle;
      tx_cnt_q      <= '0;
      tx_div_q      <= '0;
      tx_bits_q     <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      uart_tx_d_out <= 1'b1;
      uart_tx_ready <= 1'b1;
    end else begin
      tx_start_q <= uart_tx_start;
      if (pop) begin
        tx_state_q    <= TxStart;
        tx_cnt_q      <= '0;
        tx_div_q      <= div_sel(freq_control);
        tx_shift_q    <= mem[rd_ptr_q];
        tx_par_q      <= (^mem[rd_ptr_q]) ^ PARITY_ODD;
        uart_tx_d_out <= 1'b0;
        uart_tx_ready <= 1'b0;
      end else begin
        case (tx_state_q)
          TxStart: begin
            if (tx_tick) begin
              tx_cnt_q      <= '0;
              tx_bits_q     <= '0;
              uart_tx_d_out <= tx_shift_q[0];
              tx_shift_q    <= tx_shift_q >> 1;
              tx_state_q    <= TxData;
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
          TxData: begin
            if (tx_tick) begin
              tx_cnt_q <= '0;
              if (tx_bits_q == LastBit) begin
                if (PARITY_EN) begin
                  tx_state_q    <= TxParity;
                  uart_tx_d_out <= tx_par_q;
                end else begin
                  tx_state_q    <= TxStop;
                  uart_tx_d_out <= 1'b1;
                end
              end else begin
                tx_bits_q     <= tx_bits_q + 1'b1;
                uart_tx_d_out <= tx_shift_q[0];
                tx_shift_q    <= tx_shift_q >> 1;
              end
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
          TxParity: begin
            if (tx_tick) begin
              tx_cnt_q      <= '0;
              tx_state_q    <= TxStop;
              uart_tx_d_out <= 1'b1;
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
          TxStop: begin
            if (tx_tick) begin
              tx_cnt_q      <= '0;
              tx_state_q    <= TxIdle;
              uart_tx_ready <= 1'b1;
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
          default: begin
            tx_state_q    <= TxIdle;
            uart_tx_d_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Directed bench: default DUT (no parity) plus a second instance with even parity.
module tb_uart_fifo_loopback;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       tx_start = 1'b0, auto_echo = 1'b0, clear_err = 1'b0;
  logic [1:0] freq_control = 2'b11;

  logic       tx_a, valid_a, ready_a, ovr_a, ferr_a, perr_a;
  logic [7:0] data_a;
  logic [3:0] count_a;
  logic       tx_b, valid_b, ready_b, ovr_b, ferr_b, perr_b;
  logic [7:0] data_b;
  logic [3:0] count_b;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, cur_div = 87;
  int valid_cnt = 0, valid_cyc = 0, tx_fall_cyc = 0;
  int low_run = 0, last_low = 0;
  logic [8:0] tx_q[$];

  always #50 clk = ~clk;

  uart_fifo_loopback dut (
    .clk(clk), .reset(reset), .uart_rx_d_in(rx_a), .uart_tx_start(tx_start),
    .auto_echo(auto_echo), .freq_control(freq_control), .clear_err(clear_err),
    .uart_tx_d_out(tx_a), .uart_rx_valid(valid_a), .uart_tx_ready(ready_a),
    .rx_data(data_a), .fifo_count(count_a), .overrun(ovr_a), .frame_err(ferr_a),
    .parity_err(perr_a)
  );

  uart_fifo_loopback #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_par (
    .clk(clk), .reset(reset), .uart_rx_d_in(rx_b), .uart_tx_start(1'b0),
    .auto_echo(1'b0), .freq_control(freq_control), .clear_err(clear_err),
    .uart_tx_d_out(tx_b), .uart_rx_valid(valid_b), .uart_tx_ready(ready_b),
    .rx_data(data_b), .fifo_count(count_b), .overrun(ovr_b), .frame_err(ferr_b),
    .parity_err(perr_b)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (ready_a === 1'b0) low_run++;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
  end

  // TX line decoder: samples each bit mid-period, records {stop, data}.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_a === 1'b0 && reset === 1'b1) begin
        tx_fall_cyc = cyc;
        repeat (cur_div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cur_div) @(negedge clk);
          b[i] = tx_a;
        end
        repeat (cur_div) @(negedge clk);
        tx_q.push_back({tx_a, b});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit to_par, input logic v);
    @(negedge clk);
    if (to_par) rx_b = v;
    else        rx_a = v;
    repeat (cur_div - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit to_par, input bit bad_stop,
                            input bit bad_par);
    drive_bit(to_par, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_par, d[i]);
    if (to_par) drive_bit(to_par, (^d) ^ bad_par);
    drive_bit(to_par, !bad_stop);
    if (bad_stop) drive_bit(to_par, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse(input bit which_clear);
    @(negedge clk);
    if (which_clear) clear_err = 1'b1;
    else             tx_start = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    tx_start  = 1'b0;
  endtask

  task automatic pop_tx(input string tag, input logic [7:0] exp);
    logic [8:0] got;
    got = (tx_q.size() > 0) ? tx_q.pop_front() : 9'h0EE;
    chk(tag, {23'd0, got}, {23'd0, 1'b1, exp});
  endtask

  initial begin
    logic [7:0] burst [9];
    int v0;
    burst = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34, 8'hC3, 8'h96, 8'h55};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_ready", ready_a, 1);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_flags", {ovr_a, ferr_a, perr_a}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Two frames queued, then released one per start edge
    send_frame(8'hA5, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    chk("t1_valid_cnt", valid_cnt, 2);
    chk("t1_rx_data", data_a, 8'h5A);
    chk("t1_count", count_a, 2);
    chk("t1_ready_idle", ready_a, 1);
    pulse(0);
    repeat (10 * 87 + 20) @(negedge clk);
    chk("t1_count_after1", count_a, 1);
    pulse(0);
    repeat (10 * 87 + 20) @(negedge clk);
    pop_tx("t1_tx0", 8'hA5);
    pop_tx("t1_tx1", 8'h5A);
    chk("t1_count_end", count_a, 0);
    chk("t1_ready_end", ready_a, 1);

    // Echo at 115200
    auto_echo = 1'b1;
    send_frame(8'h3C, 0, 0, 0);
    repeat (10 * 87 + 20) @(negedge clk);
    pop_tx("t2_echo", 8'h3C);
    chk("t2_latency", tx_fall_cyc - valid_cyc, 1);
    chk("t2_ready_low", last_low, 870);
    chk("t2_count", count_a, 0);

    // Echo at 9600
    freq_control = 2'b00;
    cur_div = 1042;
    send_frame(8'hC3, 0, 0, 0);
    repeat (10600) @(negedge clk);
    pop_tx("t3_echo9600", 8'hC3);
    chk("t3_ready_low", last_low, 10420);
    freq_control = 2'b11;
    cur_div = 87;
    auto_echo = 1'b0;

    // Overflow with nine frames
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) send_frame(burst[i], 0, 0, 0);
    chk("t4_count8", count_a, 8);
    chk("t4_no_ovr", ovr_a, 0);
    send_frame(burst[8], 0, 0, 0);
    chk("t4_count_full", count_a, 8);
    chk("t4_ovr", ovr_a, 1);
    chk("t4_rx_data", data_a, 8'h55);
    chk("t4_valid9", valid_cnt - v0, 9);
    pulse(1);
    chk("t4_ovr_clear", ovr_a, 0);
    tx_q.delete();
    auto_echo = 1'b1;
    repeat (8 * 870 + 200) @(negedge clk);
    auto_echo = 1'b0;
    for (int i = 0; i < 8; i++) pop_tx($sformatf("t4_drain%0d", i), burst[i]);
    chk("t4_drained", count_a, 0);

    // Framing error
    v0 = valid_cnt;
    send_frame(8'h81, 0, 1, 0);
    chk("t5_ferr", ferr_a, 1);
    chk("t5_no_valid", valid_cnt - v0, 0);
    chk("t5_count", count_a, 0);
    pulse(1);
    chk("t5_ferr_clear", ferr_a, 0);

    // Even parity instance: good frame, then bad parity frame
    send_frame(8'hA5, 1, 0, 0);
    chk("t6_par_good_cnt", count_b, 1);
    chk("t6_par_good_err", perr_b, 0);
    send_frame(8'h3C, 1, 0, 1);
    chk("t6_perr", perr_b, 1);
    chk("t6_par_drop_cnt", count_b, 1);
    chk("t6_par_data_held", data_b, 8'hA5);

    // Short glitch on idle line
    v0 = valid_cnt;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (26) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("t7_glitch_valid", valid_cnt - v0, 0);
    chk("t7_glitch_flags", {ovr_a, ferr_a, perr_a}, 0);
    chk("t7_glitch_count", count_a, 0);

    // Start edge on empty FIFO is not remembered
    pulse(0);
    repeat (20) @(negedge clk);
    chk("t8_empty_tx", tx_a, 1);
    chk("t8_empty_ready", ready_a, 1);
    send_frame(8'h00, 0, 0, 0);
    repeat (100) @(negedge clk);
    chk("t8_count_kept", count_a, 1);
    chk("t8_ready_kept", ready_a, 1);

    // Reset in the middle of a data bit
    pulse(0);
    repeat (3 * 87) @(negedge clk);
    chk("t9_tx_low", tx_a, 0);
    #10 reset = 1'b0;
    #1;
    chk("t9_tx_high", tx_a, 1);
    chk("t9_count", count_a, 0);
    chk("t9_ready", ready_a, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
